force_cache: RTL and testbench
==============================

# force_cache

Per-home-cell force accumulator sitting directly downstream of the ring node's force-cache output. It receives one partial-force record per cycle with no backpressure and sums it into a per-particle x/y/z accumulator held in on-chip RAM. It serves read-and-clear requests from the motion-update stage and clears the whole array on command between time steps.

## Interface
- `NUM_PARTICLES`, 64: accumulator entries per home cell.
- `FORCE_WIDTH`, 32: signed width of each force component and each accumulator.
- `PID_WIDTH`, `$clog2(NUM_PARTICLES)`: particle index width.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  `force_data_t`  partial force record: `particle_id`, `force_x`, `force_y`, `force_z`.
- `in_valid`  in  1  record valid. Always accepted; there is no ready signal.
- `rd_en`  in  1  read-and-clear request.
- `rd_addr`  in  `PID_WIDTH`  entry to read.
- `rd_ready`  out  1  read request accepted this cycle.
- `rd_data`  out  `3*FORCE_WIDTH`  `{z,y,x}` sums.
- `rd_valid`  out  1  `rd_data` valid.
- `clr_start`  in  1  start a clear sweep.
- `busy`  out  1  clear sweep in progress.
- `err`  out  2  sticky flags: [0] saturation occurred; [1] record dropped (bad id or arrived during clear).

## Operation
- Pipeline, one operation per cycle:
  - S0 issues the operation: an accumulate when `in_valid`; otherwise a read-clear when `rd_en`.
  - S1 takes the RAM data, applies forwarding, computes the result and writes the RAM.
  - S2 registers `rd_data` for read-clears.
- Arbitration:
  - `in_valid` always wins the slot.
  - `rd_ready = ~in_valid & ~busy`.
  - A read request is consumed only on `rd_en & rd_ready`. The requester holds `rd_en`/`rd_addr` until then.
- Accumulate: each component is `sat(old + delta)` in `FORCE_WIDTH`-bit signed arithmetic.
  - Clamp to `+2^(W-1)-1` / `-2^(W-1)`.
  - Any clamp sets `err[0]`.
- Read-clear: outputs the current sums and writes zero to the entry in the same S1 write.
- Hazards: an operation reading an address written in the immediately preceding cycle uses the forwarded S1 result, not RAM. Any back-to-back sequence on one address must produce exact sequential sums.
- Bad `particle_id` (`>= NUM_PARTICLES`): the record is dropped, RAM is unchanged, and `err[1]` is set.
- FSM states:
  - IDLE: `clr_start` → CLEAR with sweep counter 0, `busy=1` from the next cycle.
  - CLEAR: writes zero to entry = counter, counter+1 per cycle. After writing `NUM_PARTICLES-1` → IDLE.
  - `clr_start` during CLEAR is ignored.
  - `in_valid` during CLEAR: the record is dropped and `err[1]` is set. The sweep does not stall.
- `err` clears only on `rst` or `clr_start` accepted in IDLE.

## Timing
- Reset values:
  - `rd_valid=0`, `rd_data=0`, `busy=0`, `err=0`, FSM IDLE, pipeline valids 0.
  - RAM contents are undefined after `rst`; a clear sweep is required before the first use.
- Accumulate issued at cycle T is visible to any operation issued at T+1 or later.
- Read-clear accepted at T: `rd_valid=1` at T+2 for exactly one cycle. The entry reads zero for operations issued at T+1.
- Throughput: one accumulate or one read per cycle.
- Clear sweep takes exactly `NUM_PARTICLES` cycles. `busy` falls the cycle after the last write.
- `rst` mid-operation: pipeline contents are discarded, the FSM goes to IDLE, and there is no `rd_valid` pulse.

## Structure
- `md_pkg` holds:
  - the `force_data_t` fields listed above;
  - `FORCE_WIDTH`;
  - the `sat_add` function, so other accumulators reuse it.
- Sub-module `force_acc_ram`: simple dual-port, 1-cycle registered read, write-first-agnostic. Forwarding lives in `force_cache`, so the RAM carries no read-during-write requirement.

## Test plan
- Clear sweep, then accumulate id 5 with (1,2,3) twice on consecutive cycles, then read id 5 → `rd_data` (2,4,6) at T+2; immediate re-read → (0,0,0).
- Records with `force_x` = `0x7FFFFFF0` then `+0x20` to id 0 → read 0x7FFFFFFF, `err[0]=1`.
- `in_valid` and `rd_en` held high together for 3 cycles → `rd_ready=0` throughout, no `rd_valid`; read completes the cycle after `in_valid` drops.
- Record with `particle_id=64` (`NUM_PARTICLES=64`) → RAM unchanged, `err[1]=1`.
- Record during CLEAR → dropped, `err[1]=1`, `busy` high exactly 64 cycles.
- Random 2000-record stream over 8 ids vs scoreboard, then read all → exact match; assert `rst` mid-stream → outputs at reset values next cycle.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared force record type, widths and saturating add for MD force accumulators.
package md_pkg;

    localparam int FORCE_WIDTH = 32;
    localparam int ID_WIDTH    = 16;

    typedef struct packed {
        logic [ID_WIDTH-1:0]           particle_id;
        logic signed [FORCE_WIDTH-1:0] force_x;
        logic signed [FORCE_WIDTH-1:0] force_y;
        logic signed [FORCE_WIDTH-1:0] force_z;
    } force_data_t;

    typedef struct packed {
        logic                   sat;
        logic [FORCE_WIDTH-1:0] sum;
    } sat_res_t;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    // Overflow only when both operands share a sign the sum lost; clamp toward that sign.
    function automatic sat_res_t sat_add(input logic [FORCE_WIDTH-1:0] a, input logic [FORCE_WIDTH-1:0] b);
        logic [FORCE_WIDTH-1:0] s;
        sat_res_t r;
        s = a + b;
        r.sat = (a[FORCE_WIDTH-1] == b[FORCE_WIDTH-1]) && (s[FORCE_WIDTH-1] != a[FORCE_WIDTH-1]);
        r.sum = r.sat ? {a[FORCE_WIDTH-1], {(FORCE_WIDTH-1){~a[FORCE_WIDTH-1]}}} : s;
        return r;
    endfunction

endpackage

// File: rtl/force_acc_ram.sv
// force_acc_ram: simple dual-port accumulator RAM with one-cycle registered read.
module force_acc_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/force_cache.sv
// force_cache: per-home-cell x/y/z force accumulator with read-and-clear and clear sweep.
// S0 issues (RAM read), S1 computes and writes back with forwarding, S2 registers read data.
module force_cache
    import md_pkg::*;
#(
    parameter int NUM_PARTICLES = 64,
    parameter int PID_WIDTH     = $clog2(NUM_PARTICLES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  force_data_t              in_data,
    input  logic                     in_valid,
    input  logic                     rd_en,
    input  logic [PID_WIDTH-1:0]     rd_addr,
    output logic                     rd_ready,
    output logic [3*FORCE_WIDTH-1:0] rd_data,
    output logic                     rd_valid,
    input  logic                     clr_start,
    output logic                     busy,
    output logic [1:0]               err
);

    localparam int DW = 3*FORCE_WIDTH;
    localparam logic [PID_WIDTH-1:0] LAST = PID_WIDTH'(NUM_PARTICLES-1);

    clr_state_t           state_q;
    logic [PID_WIDTH-1:0] cnt_q;
    logic                 busy_q;
    logic [1:0]           err_q;

    logic                 s1_valid_q, s1_rd_q, s1_fwd_q;
    logic [PID_WIDTH-1:0] s1_addr_q;
    logic [DW-1:0]        s1_delta_q, fwd_data_q;
    logic                 rd_valid_q;
    logic [DW-1:0]        rd_data_q;

    logic                 id_ok, acc_d, drop_d, rd_go_d, s0_valid_d, fwd_d, clr_go;
    logic [PID_WIDTH-1:0] s0_addr_d;
    logic [DW-1:0]        ram_rdata, old, s1_wdata;
    logic                 s1_we, sat_hit;
    sat_res_t             sx, sy, sz;

    assign id_ok      = int'(in_data.particle_id) < NUM_PARTICLES;
    assign rd_ready   = ~in_valid & ~busy_q;
    assign acc_d      = in_valid & ~busy_q & id_ok;
    assign drop_d     = in_valid & (busy_q | ~id_ok);
    assign rd_go_d    = rd_en & rd_ready;
    assign s0_valid_d = acc_d | rd_go_d;
    assign s0_addr_d  = in_valid ? in_data.particle_id[PID_WIDTH-1:0] : rd_addr;
    assign clr_go     = (state_q == IDLE) & clr_start;

    // The RAM's registered read misses the write landing on the same edge, so take S1's result.
    assign old      = s1_fwd_q ? fwd_data_q : ram_rdata;
    assign sx       = sat_add(old[0 +: FORCE_WIDTH], s1_delta_q[0 +: FORCE_WIDTH]);
    assign sy       = sat_add(old[FORCE_WIDTH +: FORCE_WIDTH], s1_delta_q[FORCE_WIDTH +: FORCE_WIDTH]);
    assign sz       = sat_add(old[2*FORCE_WIDTH +: FORCE_WIDTH], s1_delta_q[2*FORCE_WIDTH +: FORCE_WIDTH]);
    assign s1_wdata = s1_rd_q ? '0 : {sz.sum, sy.sum, sx.sum};
    assign s1_we    = s1_valid_q & ~busy_q;
    assign sat_hit  = s1_valid_q & ~s1_rd_q & (sx.sat | sy.sat | sz.sat);
    assign fwd_d    = s0_valid_d & s1_we & (s1_addr_q == s0_addr_d);

    // The sweep owns the write port; an op left in S1 at sweep start is zeroed by the sweep anyway.
    force_acc_ram #(.DEPTH(NUM_PARTICLES), .WIDTH(DW), .AW(PID_WIDTH)) u_ram (
        .clk   (clk),
        .we    (busy_q | s1_we),
        .waddr (busy_q ? cnt_q : s1_addr_q),
        .wdata (busy_q ? '0 : s1_wdata),
        .raddr (s0_addr_d),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_fwd_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            s1_valid_q <= s0_valid_d;
            s1_fwd_q   <= fwd_d;
            rd_valid_q <= s1_valid_q & s1_rd_q;
            if (s1_valid_q & s1_rd_q) rd_data_q <= old;
        end
    end

    always_ff @(posedge clk) begin
        s1_rd_q    <= ~acc_d;
        s1_addr_q  <= s0_addr_d;
        s1_delta_q <= {in_data.force_z, in_data.force_y, in_data.force_x};
        fwd_data_q <= s1_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            err_q <= (clr_go ? 2'b00 : err_q) | {drop_d, sat_hit};
            if (state_q == IDLE) begin
                if (clr_start) begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_force_cache.sv
// tb_force_cache: directed and random checks of force_cache against a sequential-semantics model.
module tb_force_cache;
    import md_pkg::*;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    force_data_t in_data = '0;
    logic        in_valid = 1'b0, rd_en = 1'b0, clr_start = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic        rd_ready, rd_valid, busy;
    logic [95:0] rd_data;
    logic [1:0]  err;

    always #5 clk = ~clk;

    force_cache dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .clr_start(clr_start),
        .busy(busy), .err(err)
    );

    int total = 0, bad = 0;
    bit chk_en = 0;
    logic [95:0] got_q[$];
    int rv_count = 0;

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: every operation takes effect at issue; only output timing is delayed.
    typedef struct { int due; logic [95:0] d; bit known; } pend_t;
    longint     m [64][3];
    pend_t      pq[$];
    int         clr_left = 0;
    logic [1:0] err_m = 0;
    bit         sat_prev = 0, known = 0;
    int         cyc = 0;

    always @(negedge clk) begin : model
        bit         drop, sat_now;
        logic [1:0] err_n;
        int         a;
        longint     s, dl;
        if (chk_en) begin
            chk("busy", busy, clr_left > 0);
            chk("err", err, err_m);
            chk("rd_ready", rd_ready, !in_valid && clr_left == 0);
            if (pq.size() > 0 && pq[0].due == cyc) begin
                chk("rd_valid", rd_valid, 1);
                if (pq[0].known) chk("rd_data", rd_data, pq[0].d);
                void'(pq.pop_front());
            end else chk("rd_valid", rd_valid, 0);
        end
        if (rd_valid === 1'b1) begin
            got_q.push_back(rd_data);
            rv_count++;
        end
        if (rst) begin
            pq.delete();
            clr_left = 0; err_m = 0; sat_prev = 0; known = 0;
        end else begin
            drop = 0; sat_now = 0;
            if (in_valid) begin
                if (clr_left > 0 || in_data.particle_id >= 64) drop = 1;
                else begin
                    a = int'(in_data.particle_id);
                    for (int k = 0; k < 3; k++) begin
                        dl = k == 0 ? longint'(in_data.force_x) : k == 1 ? longint'(in_data.force_y) : longint'(in_data.force_z);
                        s = m[a][k] + dl;
                        if (s > MAXV) begin s = MAXV; sat_now = 1; end
                        if (s < MINV) begin s = MINV; sat_now = 1; end
                        m[a][k] = s;
                    end
                end
            end else if (rd_en && clr_left == 0) begin
                a = int'(rd_addr);
                pq.push_back('{due: cyc + 2, d: {32'(m[a][2]), 32'(m[a][1]), 32'(m[a][0])}, known: known});
                for (int k = 0; k < 3; k++) m[a][k] = 0;
            end
            err_n = err_m;
            if (clr_left > 0) clr_left--;
            else if (clr_start) begin
                clr_left = 64; err_n = 0; known = 1;
                for (int i = 0; i < 64; i++) for (int k = 0; k < 3; k++) m[i][k] = 0;
            end
            err_m = err_n | {drop, sat_prev};
            sat_prev = sat_now;
        end
        cyc++;
    end

    function automatic force_data_t rec(input int id, input int x, input int y, input int z);
        force_data_t r;
        r.particle_id = 16'(id);
        r.force_x = x;
        r.force_y = y;
        r.force_z = z;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input int id, input int x, input int y, input int z);
        in_valid = 1'b1;
        in_data = rec(id, x, y, z);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic rd(input int a);
        bit ok = 0;
        rd_en = 1'b1;
        rd_addr = 6'(a);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ok = rd_ready;
            tick;
            if (ok) break;
        end
        rd_en = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL rd_accept_timeout addr=%0d got=no_accept exp=accept", a);
        end
    endtask

    task automatic wait_rd(output logic [95:0] d);
        for (int i = 0; i < 20 && got_q.size() == 0; i++) tick;
        if (got_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_valid_timeout got=none exp=pulse");
            d = 'x;
        end else d = got_q.pop_front();
    endtask

    task automatic do_clear(input int inject_at, output int n);
        clr_start = 1'b1;
        tick;
        clr_start = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            in_valid = (i == inject_at);
            in_data = rec(7, 9, 9, 9);
            @(negedge clk);
            if (!busy) break;
            n++;
            tick;
        end
        in_valid = 1'b0;
        tick;
    endtask

    int sb [8][3];

    initial begin
        logic [95:0] d;
        int n, rv0, id, x, y, z;
        tick;
        tick;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_data", rd_data, 0);
        tick;
        rst = 1'b0;
        chk_en = 1;

        do_clear(-1, n);
        chk("clear_len", n, 64);
        acc(5, 1, 2, 3);
        acc(5, 1, 2, 3);
        rd(5);
        rd(5);
        wait_rd(d);
        chk("b2b_sum", d, {32'd6, 32'd4, 32'd2});
        wait_rd(d);
        chk("reread_zero", d, 96'd0);

        acc(0, 'h7FFFFFF0, 0, 0);
        acc(0, 'h20, 0, 0);
        acc(1, 0, 'h80000010, 0);
        acc(1, 0, 'hFFFFFFE0, 0);
        rd(0);
        rd(1);
        wait_rd(d);
        chk("sat_pos", d, {32'd0, 32'd0, 32'h7FFFFFFF});
        wait_rd(d);
        chk("sat_neg", d, {32'd0, 32'h80000000, 32'd0});
        tick;
        chk("sat_err", err, 2'b01);

        in_valid = 1'b1;
        in_data = rec(3, 1, 1, 1);
        rd_en = 1'b1;
        rd_addr = 6'd3;
        rv0 = rv_count;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arb_rdy_low", rd_ready, 0);
            tick;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("arb_rdy_high", rd_ready, 1);
        tick;
        rd_en = 1'b0;
        chk("arb_no_early_rv", rv_count, rv0);
        wait_rd(d);
        chk("arb_sum", d, {32'd3, 32'd3, 32'd3});
        tick;
        chk("arb_one_rv", rv_count, rv0 + 1);

        acc(0, 7, 7, 7);
        acc(64, 9, 9, 9);
        rd(0);
        wait_rd(d);
        chk("badid_unchanged", d, {32'd7, 32'd7, 32'd7});
        chk("badid_err", err, 2'b11);

        acc(7, 5, 5, 5);
        do_clear(5, n);
        chk("clear_len_drop", n, 64);
        chk("clear_drop_err", err, 2'b10);
        rd(7);
        wait_rd(d);
        chk("cleared_entry", d, 96'd0);

        for (int i = 0; i < 8; i++) for (int k = 0; k < 3; k++) sb[i][k] = 0;
        for (int r = 0; r < 2000; ) begin
            if ($urandom_range(0, 3) != 0) begin
                id = int'($urandom_range(0, 7));
                x = int'($urandom_range(0, 2000)) - 1000;
                y = int'($urandom_range(0, 2000)) - 1000;
                z = int'($urandom_range(0, 2000)) - 1000;
                sb[id][0] += x; sb[id][1] += y; sb[id][2] += z;
                in_valid = 1'b1;
                in_data = rec(id, x, y, z);
                r++;
            end else in_valid = 1'b0;
            tick;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(i);
            wait_rd(d);
            chk("rand_sum", d, {32'(sb[i][2]), 32'(sb[i][1]), 32'(sb[i][0])});
        end

        acc(64, 1, 1, 1);
        acc(2, 1, 1, 1);
        rd(2);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_rd_data", rd_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        rv0 = rv_count;
        repeat (4) tick;
        chk("midrst_no_rv", rv_count, rv0);

        clr_start = 1'b1;
        tick;
        clr_start = 1'b0;
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("clrrst_busy", busy, 0);
        tick;

        do_clear(-1, n);
        acc(2, 4, 5, 6);
        rd(2);
        wait_rd(d);
        chk("post_rst_sum", d, {32'd6, 32'd5, 32'd4});
        repeat (3) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
